// File: rtl/ram_bridge.sv
// Word-to-byte bridge: turns one 32-bit ALU read/write into four little-endian
// byte accesses on a registered-read synchronous RAM, then returns a one-cycle ack.
module ram_bridge #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           ramAddress,
  input  logic [31:0]           ramOut,
  input  logic                  readReq,
  input  logic                  writeReq,
  output logic [31:0]           ramValue,
  output logic                  readAck,
  output logic                  writeAck,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [7:0]            memWData,
  output logic                  memWe,
  input  logic [7:0]            memRData
);

  // state | meaning
  // IDLE  | waiting for a request; RAM port parked at zero
  // RD    | issuing byte reads base+idx; captures lane idx-1 (RAM read is one cycle late)
  // RDL   | captures lane 3, publishes ramValue, raises readAck
  // WR    | writing byte idx of the latched word to base+idx
  // ACK   | ack pulse cycle; requests not sampled
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RDL,
    S_WR,
    S_ACK
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [31:0]           r_wdata;
  logic [1:0]            r_idx;
  logic [23:0]           r_asm;

  logic [1:0]            w_idx_next;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [7:0]            w_wbyte_next;
  logic                  w_unused_addr;

  assign w_idx_next    = r_idx + 2'd1;
  assign w_addr_next   = r_base + ADDR_WIDTH'(w_idx_next);
  assign w_unused_addr = ^ramAddress[31:ADDR_WIDTH];

  always_comb begin
    w_wbyte_next = 8'h00;
    case (w_idx_next)
      2'd0: w_wbyte_next = r_wdata[7:0];
      2'd1: w_wbyte_next = r_wdata[15:8];
      2'd2: w_wbyte_next = r_wdata[23:16];
      2'd3: w_wbyte_next = r_wdata[31:24];
      default: w_wbyte_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_wdata  <= '0;
      r_idx    <= '0;
      r_asm    <= '0;
      ramValue <= '0;
      readAck  <= 1'b0;
      writeAck <= 1'b0;
      busy     <= 1'b0;
      memAddr  <= '0;
      memWData <= '0;
      memWe    <= 1'b0;
    end else begin
      readAck  <= 1'b0;
      writeAck <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Write has priority; a simultaneous read is dropped, not queued.
          if (writeReq || readReq) begin
            r_base   <= ramAddress[ADDR_WIDTH-1:0];
            r_wdata  <= ramOut;
            r_idx    <= 2'd0;
            busy     <= 1'b1;
            memAddr  <= ramAddress[ADDR_WIDTH-1:0];
            if (writeReq) begin
              r_state  <= S_WR;
              memWData <= ramOut[7:0];
              memWe    <= 1'b1;
            end else begin
              r_state  <= S_RD;
            end
          end
        end
        S_RD: begin
          case (r_idx)
            2'd1: r_asm[7:0]   <= memRData;
            2'd2: r_asm[15:8]  <= memRData;
            2'd3: r_asm[23:16] <= memRData;
            default: ;
          endcase
          r_idx <= w_idx_next;
          if (r_idx == 2'd3) begin
            r_state <= S_RDL;
            memAddr <= '0;
          end else begin
            memAddr <= w_addr_next;
          end
        end
        S_RDL: begin
          ramValue <= {memRData, r_asm};
          readAck  <= 1'b1;
          r_state  <= S_ACK;
        end
        S_WR: begin
          r_idx <= w_idx_next;
          if (r_idx == 2'd3) begin
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWData <= '0;
            writeAck <= 1'b1;
            r_state  <= S_ACK;
          end else begin
            memAddr  <= w_addr_next;
            memWData <= w_wbyte_next;
          end
        end
        S_ACK: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          memWe   <= 1'b0;
          memAddr <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bridge.sv
// Directed bench for ram_bridge with a registered-read byte RAM model and a
// backdoor port for preload/clear.
module tb_ram_bridge;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   ramAddress = '0;
  logic [31:0]   ramOut = '0;
  logic          readReq = 1'b0;
  logic          writeReq = 1'b0;
  logic [31:0]   ramValue;
  logic          readAck;
  logic          writeAck;
  logic          busy;
  logic [AW-1:0] memAddr;
  logic [7:0]    memWData;
  logic          memWe;
  logic [7:0]    memRData;

  logic [7:0]    mem [0:(1<<AW)-1];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [7:0]    bd_data = '0;

  int total = 0;
  int bad = 0;

  ram_bridge #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .ramAddress(ramAddress), .ramOut(ramOut),
    .readReq(readReq), .writeReq(writeReq), .ramValue(ramValue),
    .readAck(readAck), .writeAck(writeAck), .busy(busy), .memAddr(memAddr),
    .memWData(memWData), .memWe(memWe), .memRData(memRData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (memWe) mem[memAddr] <= memWData;
    memRData <= mem[memAddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  // Fixed observation window after the accept edge; cycle 0 is the cycle after E0.
  task automatic do_read(input logic [31:0] a, output logic [31:0] val,
                         output int ack_at, output int racks, output int wacks);
    ramAddress = a; readReq = 1'b1;
    tick();
    readReq = 1'b0;
    ack_at = -1; racks = 0; wacks = 0; val = '0;
    for (int i = 0; i < 12; i++) begin
      if (readAck) begin
        racks++;
        if (ack_at < 0) begin ack_at = i; val = ramValue; end
      end
      if (writeAck) wacks++;
      tick();
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic also_read,
                          input int poke_at, output int we_cnt, output int ack_at,
                          output int racks, output int wacks);
    ramAddress = a; ramOut = d; writeReq = 1'b1; readReq = also_read;
    tick();
    writeReq = 1'b0; readReq = 1'b0;
    we_cnt = 0; ack_at = -1; racks = 0; wacks = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == poke_at) begin ramAddress = 32'h40; readReq = 1'b1; end
      if (i == poke_at + 1) readReq = 1'b0;
      if (memWe) we_cnt++;
      if (writeAck) begin
        wacks++;
        if (ack_at < 0) ack_at = i;
      end
      if (readAck) racks++;
      tick();
    end
  endtask

  logic [31:0] v;
  logic [31:0] prev;
  int ack_at, racks, wacks, we_cnt;

  initial begin
    reset = 1'b0;
    for (int i = 0; i < (1 << AW); i++) bd_write(AW'(i), 8'h00);
    bd_write(11'h010, 8'h78);
    bd_write(11'h011, 8'h56);
    bd_write(11'h012, 8'h34);
    bd_write(11'h013, 8'h12);

    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ramValue", ramValue, 32'd0);
    chk("rst_memAddr", {21'b0, memAddr}, 32'd0);
    chk("rst_memWe", {31'b0, memWe}, 32'd0);
    reset = 1'b1;
    tick();

    // Directed read with per-cycle address checks.
    ramAddress = 32'h10; readReq = 1'b1;
    tick();
    readReq = 1'b0;
    chk("rd_busy", {31'b0, busy}, 32'd1);
    chk("rd_addr0", {21'b0, memAddr}, 32'h10);
    chk("rd_we0", {31'b0, memWe}, 32'd0);
    tick(); chk("rd_addr1", {21'b0, memAddr}, 32'h11);
    tick(); chk("rd_addr2", {21'b0, memAddr}, 32'h12);
    tick(); chk("rd_addr3", {21'b0, memAddr}, 32'h13);
    tick(); chk("rd_noack4", {31'b0, readAck}, 32'd0);
    tick();
    chk("rd_ack5", {31'b0, readAck}, 32'd1);
    chk("rd_value", ramValue, 32'h12345678);
    tick();
    chk("rd_ack_drop", {31'b0, readAck}, 32'd0);
    chk("rd_busy_end", {31'b0, busy}, 32'd0);
    chk("rd_hold", ramValue, 32'h12345678);
    tick();

    // Write and read-back.
    do_write(32'h20, 32'hDEADBEEF, 1'b0, -5, we_cnt, ack_at, racks, wacks);
    chk("wr_we_cycles", we_cnt, 4);
    chk("wr_ack_at", ack_at, 4);
    chk("wr_wacks", wacks, 1);
    chk("wr_ramValue_hold", ramValue, 32'h12345678);
    chk("wr_m20", {24'b0, mem[11'h020]}, 32'hEF);
    chk("wr_m21", {24'b0, mem[11'h021]}, 32'hBE);
    chk("wr_m22", {24'b0, mem[11'h022]}, 32'hAD);
    chk("wr_m23", {24'b0, mem[11'h023]}, 32'hDE);
    do_read(32'h20, v, ack_at, racks, wacks);
    chk("rb_value", v, 32'hDEADBEEF);
    chk("rb_ack_at", ack_at, 5);
    chk("rb_racks", racks, 1);

    // Address wrap.
    do_write(32'h7FE, 32'hA1B2C3D4, 1'b0, -5, we_cnt, ack_at, racks, wacks);
    chk("wrap_m7fe", {24'b0, mem[11'h7FE]}, 32'hD4);
    chk("wrap_m7ff", {24'b0, mem[11'h7FF]}, 32'hC3);
    chk("wrap_m000", {24'b0, mem[11'h000]}, 32'hB2);
    chk("wrap_m001", {24'b0, mem[11'h001]}, 32'hA1);
    do_read(32'h7FE, v, ack_at, racks, wacks);
    chk("wrap_rb", v, 32'hA1B2C3D4);

    // Unaligned read: bytes 0x11..0x14 = 56 34 12 00.
    do_read(32'h11, v, ack_at, racks, wacks);
    chk("unal_rb", v, 32'h00123456);

    // Read/write collision: write wins.
    do_write(32'h30, 32'h11223344, 1'b1, -5, we_cnt, ack_at, racks, wacks);
    chk("col_wacks", wacks, 1);
    chk("col_racks", racks, 0);
    chk("col_we_cycles", we_cnt, 4);
    chk("col_m30", {mem[11'h033], mem[11'h032], mem[11'h031], mem[11'h030]}, 32'h11223344);
    chk("col_ramValue", ramValue, 32'h00123456);

    // Read poked mid-write is ignored.
    prev = 32'h00123456;
    do_write(32'h60, 32'h55667788, 1'b0, 1, we_cnt, ack_at, racks, wacks);
    chk("bsy_wacks", wacks, 1);
    chk("bsy_racks", racks, 0);
    chk("bsy_ramValue", ramValue, prev);
    chk("bsy_m60", {mem[11'h063], mem[11'h062], mem[11'h061], mem[11'h060]}, 32'h55667788);

    // Reset after two byte writes.
    ramAddress = 32'h50; ramOut = 32'hCAFEF00D; writeReq = 1'b1;
    tick();
    writeReq = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_memWe", {31'b0, memWe}, 32'd0);
    chk("mrst_memAddr", {21'b0, memAddr}, 32'd0);
    chk("mrst_memWData", {24'b0, memWData}, 32'd0);
    chk("mrst_ramValue", ramValue, 32'd0);
    chk("mrst_writeAck", {31'b0, writeAck}, 32'd0);
    wacks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (writeAck) wacks++;
    end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (writeAck || readAck) wacks++;
    end
    chk("mrst_noack", wacks, 0);
    chk("mrst_m50", {mem[11'h053], mem[11'h052], mem[11'h051], mem[11'h050]}, 32'h0000F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
